stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/sw_pkg.sv | 67 ++++++
 rtl/sw_tick_gen.sv | 43 ++++
 rtl/stopwatch_core.sv | 182 ++++++++++++++++++
 tb/tb_stopwatch_core.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared types and BCD helpers for the stopwatch core.
//   state_t    : controller states STOP / RUN / ADJUST
//   bcd_t      : one BCD digit (0..9)
//   bcd_pair_t : tens/ones digit pair (one MM or SS field)
//   sw_count_t : full MM:SS count, packs to {min_tens,min_ones,sec_tens,sec_ones}
`timescale 1ns/1ps
package sw_pkg;

  typedef enum logic [1:0] {STOP, RUN, ADJUST} state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  typedef struct packed {
    bcd_pair_t mins;
    bcd_pair_t secs;
  } sw_count_t;

  localparam int SEC_MAX = 59;

  function automatic int pair_val(bcd_pair_t p);
    return int'(p.tens) * 10 + int'(p.ones);
  endfunction

  // Only ever called with elaboration-time constants.
  function automatic bcd_pair_t to_pair(int v);
    bcd_pair_t r;
    r.tens = 4'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

  // +1 with wrap to 00 once the field sits at max_v.
  function automatic bcd_pair_t pair_inc(bcd_pair_t p, int max_v);
    bcd_pair_t r;
    if (pair_val(p) >= max_v) begin
      r = '0;
    end else if (p.ones == 4'd9) begin
      r.tens = p.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.tens = p.tens;
      r.ones = p.ones + 4'd1;
    end
    return r;
  endfunction

  // -1 with wrap from 00 up to max_v.
  function automatic bcd_pair_t pair_dec(bcd_pair_t p, int max_v);
    bcd_pair_t r;
    if (pair_val(p) == 0) begin
      r = to_pair(max_v);
    end else if (p.ones == 4'd0) begin
      r.tens = p.tens - 4'd1;
      r.ones = 4'd9;
    end else begin
      r.tens = p.tens;
      r.ones = p.ones - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// sw_tick_gen: free-running dividers producing one-cycle strobes.
//   i_clk, i_rst_n : clock, async active-low reset
//   o_sec_tick     : 1 clk high every SIM_DIV (if non-zero) else CLK_HZ cycles
//   o_adj_tick     : 1 clk high every CLK_HZ/ADJ_HZ cycles
`timescale 1ns/1ps
module sw_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int ADJ_HZ  = 2,
  parameter int SIM_DIV = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sec_tick,
  output logic o_adj_tick
);

  localparam int SEC_DIV = (SIM_DIV != 0) ? SIM_DIV : CLK_HZ;
  localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;
  localparam int SEC_W   = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int ADJ_W   = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;

  logic [SEC_W-1:0] r_sec_cnt;
  logic [ADJ_W-1:0] r_adj_cnt;
  logic             w_sec_wrap;
  logic             w_adj_wrap;

  assign w_sec_wrap = (r_sec_cnt == SEC_W'(SEC_DIV - 1));
  assign w_adj_wrap = (r_adj_cnt == ADJ_W'(ADJ_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sec_cnt <= '0;
      r_adj_cnt <= '0;
    end else begin
      r_sec_cnt <= w_sec_wrap ? '0 : r_sec_cnt + SEC_W'(1);
      r_adj_cnt <= w_adj_wrap ? '0 : r_adj_cnt + ADJ_W'(1);
    end
  end

  assign o_sec_tick = w_sec_wrap;
  assign o_adj_tick = w_adj_wrap;

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch / count-down timer with adjust and lap.
//   clk      : single clock          RESET_N : async active-low reset
//   PAUSE    : button, edge toggles run/stop
//   ADJ      : level, high = adjust mode   SEL : adjust field (0 min, 1 sec)
//   DOWN     : level, 1 = count down       LAP : button, edge toggles freeze
//   digits   : {min_tens,min_ones,sec_tens,sec_ones}
//   running  : high in RUN     expired : 1 clk pulse when count-down hits 00:00
//   lap_hold : high while the display is frozen
`timescale 1ns/1ps
module stopwatch_core
  import sw_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int ADJ_HZ  = 2,
  parameter int MAX_MIN = 59,
  parameter int SIM_DIV = 0
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        PAUSE,
  input  logic        ADJ,
  input  logic        SEL,
  input  logic        DOWN,
  input  logic        LAP,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        lap_hold
);

  localparam int B_PAUSE = 4;
  localparam int B_LAP   = 3;
  localparam int B_ADJ   = 2;
  localparam int B_SEL   = 1;
  localparam int B_DOWN  = 0;

  // ---- input synchronisers + edge detect ----
  logic [4:0] w_raw;
  logic [4:0] r_sync1, r_sync2;
  logic       r_pause_d, r_lap_d;
  logic       w_pause_edge, w_lap_edge, w_adj, w_sel, w_down;

  assign w_raw = {PAUSE, LAP, ADJ, SEL, DOWN};

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_pause_d <= 1'b0;
      r_lap_d   <= 1'b0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_pause_d <= r_sync2[B_PAUSE];
      r_lap_d   <= r_sync2[B_LAP];
    end
  end

  assign w_pause_edge = r_sync2[B_PAUSE] & ~r_pause_d;
  assign w_lap_edge   = r_sync2[B_LAP]   & ~r_lap_d;
  assign w_adj        = r_sync2[B_ADJ];
  assign w_sel        = r_sync2[B_SEL];
  assign w_down       = r_sync2[B_DOWN];

  // ---- tick generator ----
  logic w_sec_tick, w_adj_tick;

  sw_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .ADJ_HZ (ADJ_HZ),
    .SIM_DIV(SIM_DIV)
  ) u_tick (
    .i_clk     (clk),
    .i_rst_n   (RESET_N),
    .o_sec_tick(w_sec_tick),
    .o_adj_tick(w_adj_tick)
  );

  // ---- state ----
  state_t    r_state, w_state_nxt;
  sw_count_t r_count, w_count_nxt;
  sw_count_t r_lap_val, w_lap_val_nxt;
  logic      r_lap_hold, w_lap_hold_nxt;
  logic      r_expired, w_expired_nxt;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= STOP;
      r_count    <= '0;
      r_lap_val  <= '0;
      r_lap_hold <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_lap_val  <= w_lap_val_nxt;
      r_lap_hold <= w_lap_hold_nxt;
      r_expired  <= w_expired_nxt;
    end
  end

  // ---- candidate next counts ----
  sw_count_t w_cnt_up, w_cnt_dn, w_cnt_adj;
  logic      w_is_zero;

  assign w_is_zero = (r_count == '0);

  always_comb begin
    w_cnt_up = r_count;
    if (r_count.secs == to_pair(SEC_MAX)) begin
      w_cnt_up.secs = '0;
      w_cnt_up.mins = pair_inc(r_count.mins, MAX_MIN);
    end else begin
      w_cnt_up.secs = pair_inc(r_count.secs, SEC_MAX);
    end

    // Minutes are never zero here when seconds are zero: the 00:00 case is
    // caught before this value is used.
    w_cnt_dn      = r_count;
    w_cnt_dn.secs = pair_dec(r_count.secs, SEC_MAX);
    if (r_count.secs == '0)
      w_cnt_dn.mins = pair_dec(r_count.mins, MAX_MIN);

    // Adjust touches one field only, no carry.
    w_cnt_adj = r_count;
    if (w_sel) w_cnt_adj.secs = pair_inc(r_count.secs, SEC_MAX);
    else       w_cnt_adj.mins = pair_inc(r_count.mins, MAX_MIN);
  end

  // ---- next-state / datapath control ----
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_expired_nxt  = 1'b0;
    w_lap_hold_nxt = r_lap_hold;
    w_lap_val_nxt  = r_lap_val;

    if (w_adj) begin
      // ADJ wins over any PAUSE edge or pending second tick.
      w_state_nxt = ADJUST;
      if (r_state == ADJUST && w_adj_tick) w_count_nxt = w_cnt_adj;
    end else begin
      unique case (r_state)
        STOP: begin
          if (w_pause_edge && !(w_down && w_is_zero)) w_state_nxt = RUN;
        end
        RUN: begin
          if (w_sec_tick) begin
            if (!w_down) begin
              w_count_nxt = w_cnt_up;
            end else if (w_is_zero) begin
              // Switched to count-down while at 00:00: stop, no underflow.
              w_state_nxt = STOP;
            end else begin
              w_count_nxt = w_cnt_dn;
              if (w_cnt_dn == '0) begin
                w_expired_nxt = 1'b1;
                w_state_nxt   = STOP;
              end
            end
          end
          if (w_pause_edge) w_state_nxt = STOP;
        end
        ADJUST:  w_state_nxt = STOP;
        default: w_state_nxt = STOP;
      endcase
    end

    if (w_state_nxt != RUN) begin
      w_lap_hold_nxt = 1'b0;
    end else if (r_state == RUN && w_lap_edge) begin
      w_lap_hold_nxt = ~r_lap_hold;
      if (!r_lap_hold) w_lap_val_nxt = r_count;
    end
  end

  assign digits   = r_lap_hold ? r_lap_val : r_count;
  assign running  = (r_state == RUN);
  assign expired  = r_expired;
  assign lap_hold = r_lap_hold;

endmodule

// File: tb/tb_stopwatch_core.sv
`timescale 1ns/1ps
module tb_stopwatch_core;

  localparam int P_MAX = 59;
  localparam int SDIV  = 10;   // SIM_DIV
  localparam int ADIV  = 20;   // CLK_HZ / ADJ_HZ = 40 / 2

  logic        clk = 1'b0;
  logic        RESET_N, PAUSE, ADJ, SEL, DOWN, LAP;
  logic [15:0] digits;
  logic        running, expired, lap_hold;

  always #5 clk = ~clk;

  stopwatch_core #(
    .CLK_HZ (40),
    .ADJ_HZ (2),
    .MAX_MIN(P_MAX),
    .SIM_DIV(SDIV)
  ) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .PAUSE   (PAUSE),
    .ADJ     (ADJ),
    .SEL     (SEL),
    .DOWN    (DOWN),
    .LAP     (LAP),
    .digits  (digits),
    .running (running),
    .expired (expired),
    .lap_hold(lap_hold)
  );

  int cyc;
  always @(posedge clk or negedge RESET_N)
    if (!RESET_N) cyc <= 0;
    else          cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // Count kept as total seconds; raw inputs become visible two clocks after
  // being sampled, edges compare that against the clock before.
  typedef struct packed {
    int         total;
    int         lapv;
    int         k;
    logic       run, adj, lap, exp;
    logic [2:0] hp, hl, ha, hs, hd;
  } mstate_t;

  localparam mstate_t M_RST = '0;
  mstate_t m;

  function automatic logic [15:0] bcd(int t);
    int mm, sc;
    mm = t / 60;
    sc = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic mstate_t model_step(mstate_t c, logic pb, logic lb,
                                         logic ab, logic sb, logic db);
    mstate_t n;
    logic s_adj, pe, le, sd, ss, sec, adt;
    int mm, sc;
    n     = c;
    n.k   = c.k + 1;
    n.exp = 1'b0;
    s_adj = c.ha[1];
    ss    = c.hs[1];
    sd    = c.hd[1];
    pe    = c.hp[1] & ~c.hp[2];
    le    = c.hl[1] & ~c.hl[2];
    sec   = (n.k % SDIV) == 0;
    adt   = (n.k % ADIV) == 0;
    if (c.adj) begin
      if (!s_adj) n.adj = 1'b0;
      else if (adt) begin
        mm = c.total / 60;
        sc = c.total % 60;
        if (ss) sc = (sc + 1) % 60;
        else    mm = (mm == P_MAX) ? 0 : mm + 1;
        n.total = mm * 60 + sc;
      end
    end else if (s_adj) begin
      n.adj = 1'b1;
      n.run = 1'b0;
    end else if (c.run) begin
      if (sec) begin
        if (!sd) n.total = (c.total + 1) % ((P_MAX + 1) * 60);
        else if (c.total == 0) n.run = 1'b0;
        else begin
          n.total = c.total - 1;
          if (n.total == 0) begin
            n.exp = 1'b1;
            n.run = 1'b0;
          end
        end
      end
      if (pe) n.run = 1'b0;
    end else if (pe && !(sd && c.total == 0)) begin
      n.run = 1'b1;
    end
    if (!n.run) n.lap = 1'b0;
    else if (c.run && le) begin
      n.lap = ~c.lap;
      if (!c.lap) n.lapv = c.total;
    end
    n.hp = {c.hp[1:0], pb};
    n.hl = {c.hl[1:0], lb};
    n.ha = {c.ha[1:0], ab};
    n.hs = {c.hs[1:0], sb};
    n.hd = {c.hd[1:0], db};
    return n;
  endfunction

  always @(posedge clk or negedge RESET_N)
    if (!RESET_N) m <= M_RST;
    else          m <= model_step(m, PAUSE, LAP, ADJ, SEL, DOWN);

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Every bench clock goes through here so the model is compared each cycle.
  task automatic step();
    logic [18:0] a, e;
    @(negedge clk);
    if (chk_en) begin
      a = {digits, running, expired, lap_hold};
      e = {(m.lap ? bcd(m.lapv) : bcd(m.total)), m.run, m.exp, m.lap};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_cmp cyc=%0d got d=%h r=%b e=%b l=%b want d=%h r=%b e=%b l=%b",
                 cyc, a[18:3], a[2], a[1], a[0], e[18:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // Button pulses start 5 clocks after a second tick, act 3 clocks later,
  // so they never coincide with a tick; exit at phase 8.
  task automatic press_pause();
    while (cyc % SDIV != 5) step();
    PAUSE = 1'b1;
    repeat (2) step();
    PAUSE = 1'b0;
    step();
  endtask

  task automatic press_lap();
    while (cyc % SDIV != 5) step();
    LAP = 1'b1;
    repeat (2) step();
    LAP = 1'b0;
    step();
  endtask

  // Pass exactly n second ticks, ending at phase 5.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      step();
      while (cyc % SDIV != 5) step();
    end
  endtask

  // Hold ADJ for exactly n adjust ticks on the chosen field.
  task automatic adj_run(input logic sel, input int n);
    while (cyc % ADIV != 1) step();
    SEL = sel;
    ADJ = 1'b1;
    repeat (ADIV * n) step();
    ADJ = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int nexp;
    RESET_N = 1'b0; PAUSE = 1'b0; ADJ = 1'b0; SEL = 1'b0; DOWN = 1'b0; LAP = 1'b0;
    repeat (3) step();
    check("rst_digits", digits, 16'h0000);
    check("rst_running", running, 1'b0);
    check("rst_expired", expired, 1'b0);
    check("rst_lap", lap_hold, 1'b0);
    chk_en = 1'b1;
    step();
    RESET_N = 1'b1;

    // count up 600 s, then 59:59 wrap
    press_pause();
    wait_ticks(600);
    check("up_600", digits, 16'h1000);
    check("up_running", running, 1'b1);
    press_pause();
    check("stopped", running, 1'b0);
    adj_run(1'b1, 59);
    adj_run(1'b0, 49);
    check("preset_5959", digits, 16'h5959);
    press_pause();
    wait_ticks(1);
    check("wrap_0000", digits, 16'h0000);
    check("wrap_running", running, 1'b1);
    press_pause();

    // adjust fields independently
    adj_run(1'b1, 58);
    check("adj_0058", digits, 16'h0058);
    adj_run(1'b1, 3);
    check("adj_sec_wrap", digits, 16'h0001);
    adj_run(1'b0, 59);
    check("adj_5901", digits, 16'h5901);
    adj_run(1'b0, 1);
    check("adj_min_wrap", digits, 16'h0001);

    // count down to expiry
    adj_run(1'b1, 2);
    check("preset_0003", digits, 16'h0003);
    DOWN = 1'b1;
    press_pause();
    wait_ticks(1);
    check("dn_0002", digits, 16'h0002);
    wait_ticks(1);
    check("dn_0001", digits, 16'h0001);
    nexp = 0;
    repeat (SDIV) begin
      step();
      if (expired) nexp++;
    end
    check("exp_pulse_len", nexp, 1);
    check("dn_0000", digits, 16'h0000);
    check("dn_stopped", running, 1'b0);
    press_pause();
    check("no_underflow_run", running, 1'b0);
    wait_ticks(1);
    check("no_underflow_cnt", digits, 16'h0000);

    // lap freeze
    DOWN = 1'b0;
    adj_run(1'b1, 9);
    press_pause();
    wait_ticks(1);
    check("lap_start", digits, 16'h0010);
    press_lap();
    check("lap_set", lap_hold, 1'b1);
    wait_ticks(5);
    check("lap_frozen", digits, 16'h0010);
    press_lap();
    check("lap_release", digits, 16'h0015);
    check("lap_clr", lap_hold, 1'b0);
    press_lap();
    press_pause();
    check("lap_stop_clr", lap_hold, 1'b0);
    check("lap_stop_live", digits, 16'h0017);
    press_lap();
    check("lap_ign_stop", lap_hold, 1'b0);

    // async reset mid-run
    step();
    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    adj_run(1'b0, 12);
    adj_run(1'b1, 34);
    check("preset_1234", digits, 16'h1234);
    press_pause();
    repeat (2) step();
    #1 RESET_N = 1'b0;
    #1;
    check("async_digits", digits, 16'h0000);
    check("async_running", running, 1'b0);
    step();
    step();
    RESET_N = 1'b1;

    // ADJ rise together with a PAUSE pulse: ADJUST wins
    while (cyc % ADIV != 1) step();
    SEL = 1'b0; ADJ = 1'b1; PAUSE = 1'b1;
    repeat (2) step();
    PAUSE = 1'b0;
    repeat (ADIV - 2) step();
    ADJ = 1'b0;
    repeat (4) step();
    check("adj_prio_digits", digits, 16'h0100);
    check("adj_prio_running", running, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
